// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types and default sizing for the round-robin grant arbiter.
// The FSM state encoding lives here so the top and the bench agree on it.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEF_N        = 8;
  localparam int DEF_IW       = 3;
  localparam int DEF_MAX_HOLD = 16;

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Level-sensitive requests; the grant side holds until done, drop or timeout.
import arb_pkg::*;

interface decoder_rr_arbiter_if #(
  parameter int N  = DEF_N,
  parameter int IW = DEF_IW
);

  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid;
  logic          timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );

endinterface

// File: rtl/decoder_rr_arbiter_onehot_decoder.sv
// Binary index to one-hot vector, zero when not enabled; purely combinational.
// No state, no flow control: output follows inputs in the same cycle.
module onehot_decoder #(
  parameter int IW = 3
) (
  input  logic [IW-1:0]      idx_i,
  input  logic               en_i,
  output logic [(2**IW)-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter with a bounded hold time; grant registered one edge after req.
// Grantee keeps the resource until done, request drop or MAX_HOLD cycles elapse.
import arb_pkg::*;

module decoder_rr_arbiter #(
  parameter int N        = DEF_N,
  parameter int IW       = DEF_IW,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 rst,
  decoder_rr_arbiter_if.slave  bus
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  state_t        state_q;
  logic [IW-1:0] ptr_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] gnt_idx_q;
  logic          gnt_valid_q;
  logic          timeout_q;

  logic          sel_vld;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] cand;
  logic          hold_hit;
  logic          grantee_req;
  logic          release_now;

  // First requester at or above ptr; IW-bit addition wraps modulo N for free.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr_q + IW'(i);
      if (!sel_vld && bus.req[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  assign hold_hit    = (cnt_q == CW'(MAX_HOLD - 1));
  assign grantee_req = bus.req[gnt_idx_q];
  assign release_now = bus.done || !grantee_req || hold_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_vld) begin
            state_q     <= GRANT;
            gnt_idx_q   <= sel_idx;
            gnt_valid_q <= 1'b1;
            cnt_q       <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state_q     <= IDLE;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            ptr_q       <= gnt_idx_q + IW'(1);
            cnt_q       <= '0;
            // Only a pure expiry counts as a forced release.
            timeout_q   <= hold_hit && !bus.done && grantee_req;
          end else if (cnt_q != CW'(MAX_HOLD)) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  onehot_decoder #(.IW(IW)) u_dec (
    .idx_i    (gnt_idx_q),
    .en_i     (gnt_valid_q),
    .onehot_o (bus.gnt)
  );

  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: fixed vector table, hand sequences, then random traffic
// compared against a cycle-count reference model of the arbitration rules.
module tb_decoder_rr_arbiter;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int MH = 16;

  logic clk;
  logic rst;

  decoder_rr_arbiter_if #(.N(N), .IW(IW)) bus ();

  decoder_rr_arbiter #(.N(N), .IW(IW), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the resource, for how many cycles, and the rotation start.
  bit m_busy;
  int m_owner;
  int m_held;
  int m_ptr;
  bit m_tmo;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       tmo;
  } vec_t;

  vec_t tbl [15];

  task automatic model_step(input logic [7:0] r, input logic d, input logic rs);
    bit found;
    if (rs) begin
      m_busy = 0; m_owner = 0; m_held = 0; m_ptr = 0; m_tmo = 0;
    end else if (!m_busy) begin
      m_tmo = 0;
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && r[(m_ptr + k) % N]) begin
          found   = 1;
          m_owner = (m_ptr + k) % N;
        end
      end
      if (found) begin
        m_busy = 1;
        m_held = 1;
      end
    end else begin
      if (d || !r[m_owner] || m_held == MH) begin
        m_tmo   = (m_held == MH) && !d && r[m_owner];
        m_busy  = 0;
        m_ptr   = (m_owner + 1) % N;
        m_owner = 0;
        m_held  = 0;
      end else begin
        m_held++;
        m_tmo = 0;
      end
    end
  endtask

  function automatic logic [12:0] m_out();
    logic [7:0] g;
    logic [2:0] ix;
    g  = m_busy ? 8'(1 << m_owner) : 8'h00;
    ix = m_busy ? 3'(m_owner) : 3'd0;
    return {g, ix, m_busy, m_tmo};
  endfunction

  function automatic logic [12:0] dut_out();
    return {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout};
  endfunction

  task automatic drive(input logic [7:0] r, input logic d, input logic rs);
    rst      = rs;
    bus.req  = r;
    bus.done = d;
    model_step(r, d, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {gnt,idx,vld,tmo}=%h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    logic [7:0] r;
    logic       d;
    logic       rs;

    // rst, req, done -> gnt, idx, vld, tmo (state after the edge)
    tbl[0]  = '{1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 8'h80, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'hFF, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h30, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'h30, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 8'h30, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};

    rst = 1'b1; bus.req = '0; bus.done = 1'b0;
    drive(8'h00, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b1);
    chk("reset_state", dut_out(), 13'h0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].req, tbl[i].done, tbl[i].rst);
      chk($sformatf("vec%0d", i), dut_out(),
          {tbl[i].gnt, tbl[i].idx, tbl[i].vld, tbl[i].tmo});
    end

    // Full rotation under constant contention, one idle cycle per handover.
    drive(8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      drive(8'hFF, 1'b0, 1'b0);
      chk($sformatf("rr_grant%0d", k), dut_out(), {8'(1 << (k % 8)), 3'(k % 8), 1'b1, 1'b0});
      drive(8'hFF, 1'b1, 1'b0);
      chk($sformatf("rr_idle%0d", k), dut_out(), 13'h0);
    end

    // Hold expiry: 16 granted cycles, timeout pulse, then regrant of the same requester.
    drive(8'h00, 1'b0, 1'b1);
    drive(8'h04, 1'b0, 1'b0);
    chk("hold_first", dut_out(), {8'h04, 3'd2, 1'b1, 1'b0});
    for (int j = 1; j < MH; j++) begin
      drive(8'h04, 1'b0, 1'b0);
      chk($sformatf("hold%0d", j), dut_out(), {8'h04, 3'd2, 1'b1, 1'b0});
    end
    drive(8'h04, 1'b0, 1'b0);
    chk("timeout_pulse", dut_out(), {8'h00, 3'd0, 1'b0, 1'b1});
    drive(8'h04, 1'b0, 1'b0);
    chk("timeout_regrant", dut_out(), {8'h04, 3'd2, 1'b1, 1'b0});
    for (int j = 1; j < MH; j++) drive(8'h04, 1'b0, 1'b0);
    chk("hold_last_again", dut_out(), {8'h04, 3'd2, 1'b1, 1'b0});
    drive(8'h04, 1'b1, 1'b0);
    chk("done_suppresses_tmo", dut_out(), 13'h0);

    // Random traffic with sticky requests so long holds and expiries occur.
    drive(8'h00, 1'b0, 1'b1);
    r = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) r = 8'($urandom());
      if ($urandom_range(15) == 0) r = 8'h00;
      d  = ($urandom_range(23) == 0);
      rs = ($urandom_range(299) == 0);
      drive(r, d, rs);
      chk("random", dut_out(), m_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish before 1000000");
    $fatal(1);
  end

endmodule
